// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits
// per clock with a registered inter-chunk carry, framed by start/busy/done.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  operation request, sampled only while busy_o=0
//   sub_i    0: s = a + b + cin, 1: s = a - b - cin (a + ~b + !cin)
//   a_i      operand A, captured on the accepting edge
//   b_i      operand B, captured on the accepting edge
//   cin_i    carry-in (add) / borrow-in (subtract)
//   busy_o   operation in progress
//   done_o   one-cycle pulse on the first cycle a new result is valid
//   s_o      result, held until the next completion
//   cout_o   raw carry out of the MSB (subtract: 1 means no borrow)
//   ovf_o    signed overflow (carry into MSB xor carry out of MSB)
module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already conditionally inverted for subtract
  logic [WIDTH-1:0] r_q, r_d;     // partial result being assembled
  logic             c_q, c_d;     // carry between chunks
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK:0]   sum_c;
  logic             msb_cin_c;
  logic [WIDTH-1:0] r_ins_c;
  int unsigned      shift_c;

  // Chunk adder: the only combinational carry path in the design.
  always_comb begin
    shift_c   = 32'(k_q) * CHUNK;
    a_chunk_c = CHUNK'(a_q >> shift_c);
    b_chunk_c = CHUNK'(b_q >> shift_c);
    sum_c     = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + (CHUNK + 1)'(c_q);
    // Carry into the chunk MSB recovered from the sum bit; only used on the last chunk.
    msb_cin_c = a_chunk_c[CHUNK-1] ^ b_chunk_c[CHUNK-1] ^ sum_c[CHUNK-1];
    // r_q is cleared on accept, so OR-ing the chunk into place is sufficient.
    r_ins_c   = r_q | (WIDTH'(sum_c[CHUNK-1:0]) << shift_c);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    c_d    = c_q;
    k_d    = k_q;
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d = a_i;
          b_d = b_i ^ {WIDTH{sub_i}};
          c_d = cin_i ^ sub_i;
          k_d = '0;
          r_d = '0;
        end
      end
      S_RUN: begin
        r_d = r_ins_c;
        c_d = sum_c[CHUNK];
        if (k_q == K_LAST) begin
          s_d    = r_ins_c;
          cout_d = sum_c[CHUNK];
          ovf_d  = msb_cin_c ^ sum_c[CHUNK];
          done_d = 1'b1;
          k_d    = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        k_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      k_q    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      c_q    <= c_d;
      k_q    <= k_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = done_q;
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: self-checking bench for chunked_adder (16/4 and 8/8).
module tb_chunked_adder;

  localparam int unsigned N16 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] s;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  s8;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub),
    .a_i(a), .b_i(b), .cin_i(cin), .busy_o(busy), .done_o(done),
    .s_o(s), .cout_o(cout), .ovf_o(ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .sub_i(sub8),
    .a_i(a8), .b_i(b8), .cin_i(cin8), .busy_o(busy8), .done_o(done8),
    .s_o(s8), .cout_o(cout8), .ovf_o(ovf8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: returns {ovf, cout, s} for a w-bit operation.
  function automatic logic [17:0] ref_op(input logic [15:0] ra, input logic [15:0] rb,
                                         input logic rcin, input logic rsub, input int w);
    logic [31:0] mask, av, bv, full;
    logic [15:0] rs;
    logic co, ov;
    mask = (32'd1 << w) - 32'd1;
    av   = {16'h0, ra} & mask;
    bv   = rsub ? (~{16'h0, rb}) & mask : {16'h0, rb} & mask;
    full = av + bv + 32'(rcin ^ rsub);
    rs   = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (rs[w-1] != av[w-1]);
    return {ov, co, rs};
  endfunction

  // Transaction-level model of the 16-bit instance.
  logic        m_busy, m_done, m_cout, m_ovf;
  logic [15:0] m_s;
  logic [17:0] m_pend;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_s <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      m_pend <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_left <= N16;
          m_pend <= ref_op(a, b, cin, sub, 16);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_ovf, m_cout, m_s} <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("s",    32'(s),    32'(m_s));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("ovf",  32'(ovf),  32'(m_ovf));
    end
  end

  // Waits (bounded) for done, counting negedges from the given start value.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Launch one 16-bit op from a negedge and wait for its completion.
  task automatic op16(input logic [15:0] oa, input logic [15:0] ob,
                      input logic ocin, input logic osub, output int lat);
    start = 1'b1; a = oa; b = ob; cin = ocin; sub = osub;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic op8(input logic [7:0] oa, input logic [7:0] ob,
                     input logic ocin, input logic osub, input string name);
    logic [17:0] e;
    int lat;
    e = ref_op({8'h0, oa}, {8'h0, ob}, ocin, osub, 8);
    start8 = 1'b1; a8 = oa; b8 = ob; cin8 = ocin; sub8 = osub;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"},  32'(lat), 32'd2);
    chk({name, "_s"},    32'(s8), 32'(e[7:0]));
    chk({name, "_cout"}, 32'(cout8), 32'(e[16]));
    chk({name, "_ovf"},  32'(ovf8), 32'(e[17]));
  endtask

  initial begin
    int lat;
    int seen;
    start = 0; sub = 0; cin = 0; a = '0; b = '0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;

    // Pin the reference model with hand-computed values.
    chk("model_7fff_p1", 32'(ref_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16)), 32'h28000);
    chk("model_8000_m1", 32'(ref_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16)), 32'h37FFF);
    chk("model_5_m7",    32'(ref_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16)), 32'h0FFFE);

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s",    32'(s),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    op16(16'h0001, 16'h0003, 1'b0, 1'b0, lat);
    chk("add_lat", 32'(lat), 32'd5);
    chk("add_s", 32'(s), 32'h0004);
    chk("add_cout", 32'(cout), 32'd0);
    op16(16'h0001, 16'h0003, 1'b1, 1'b0, lat);
    chk("addc_s", 32'(s), 32'h0005);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    chk("ripple_s", 32'(s), 32'h0000);
    chk("ripple_cout", 32'(cout), 32'd1);
    chk("ripple_ovf", 32'(ovf), 32'd0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    chk("sovf_s", 32'(s), 32'h8000);
    chk("sovf_ovf", 32'(ovf), 32'd1);
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    chk("sub_s", 32'(s), 32'hFFFE);
    chk("sub_cout", 32'(cout), 32'd0);
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    chk("subovf_s", 32'(s), 32'h7FFF);
    chk("subovf_cout", 32'(cout), 32'd1);
    chk("subovf_ovf", 32'(ovf), 32'd1);

    // Start pulses while busy must be ignored.
    start = 1'b1; a = 16'h0010; b = 16'h0020; cin = 0; sub = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    a = 16'h3333; b = 16'h4444;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat);
    chk("ignore_lat", 32'(lat), 32'd5);
    chk("ignore_s", 32'(s), 32'h0030);

    // Start in the done cycle is accepted immediately.
    start = 1'b1; a = 16'h0100; b = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done(1, lat);
    chk("b2b_lat", 32'(lat), 32'd5);
    chk("b2b_s", 32'(s), 32'h0300);

    // Asynchronous reset two edges into an operation aborts it.
    start = 1'b1; a = 16'h1234; b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s", 32'(s), 32'h0000);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);

    // Single-chunk configuration.
    op8(8'h7F, 8'h01, 1'b0, 1'b0, "w8_ovf");
    chk("w8_lit_s", 32'(s8), 32'h80);
    chk("w8_lit_ovf", 32'(ovf8), 32'd1);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "w8_ripple");
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "w8_rand");
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
